// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: it fetches instructions, decodes them,
// sequences memory accesses and branches, drives the datapath enables and counts retired instructions.
module cpu_control_fsm #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic [DATA_W-1:0]      instr_in,
  input  logic                   mem_ready,
  input  logic [4:0]             flags,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   addr_sel,
  output logic                   ir_en,
  output logic                   pc_en,
  output logic [1:0]             pc_sel,
  output logic                   reg_we,
  output logic [2**REG_AW-1:0]   rdst_onehot,
  output logic [REG_AW-1:0]      rdst_addr,
  output logic [REG_AW-1:0]      rsrc_addr,
  output logic [7:0]             alu_op,
  output logic                   imm_mux,
  output logic [IMM_W-1:0]       imm_out,
  output logic                   wb_sel,
  output logic                   flag_en,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired
);
  localparam int NUM_REGS = 2**REG_AW;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_ALU, S_LD, S_LDWB, S_ST, S_BR
  } state_t;

  typedef enum logic [2:0] {K_R, K_IMM, K_LD, K_ST, K_JC, K_BC, K_ILL} kind_t;

  function automatic kind_t classify(input logic [3:0] op, input logic [3:0] ext);
    case (op)
      4'h0: return K_R;
      4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'h9, 4'hB, 4'hD: return K_IMM;
      4'h4: begin
        case (ext)
          4'h0:    return K_LD;
          4'h4:    return K_ST;
          4'hC:    return K_JC;
          default: return K_ILL;
        endcase
      end
      4'hC:    return K_BC;
      default: return K_ILL;
    endcase
  endfunction

  // flags are packed {N,Z,F,L,C}
  function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] f);
    logic n, z, fl, l, c;
    {n, z, fl, l, c} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return fl;
      4'h9: return !fl;
      4'hA: return !l && !z;
      4'hB: return l || z;
      4'hC: return !n && !z;
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     ir_q, ir_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d, addr_sel_q, addr_sel_d;
  logic                  ir_en_q, ir_en_d, pc_en_q, pc_en_d, reg_we_q, reg_we_d;
  logic [1:0]            pc_sel_q, pc_sel_d;
  logic [NUM_REGS-1:0]   onehot_q, onehot_d;
  logic                  imm_mux_q, imm_mux_d, wb_sel_q, wb_sel_d;
  logic                  flag_en_q, flag_en_d, illegal_q, illegal_d;
  logic [CNT_W-1:0]      retired_q, retired_d;
  kind_t                 kind;
  logic                  req_done, st_done;

  assign kind     = classify(ir_q[15:12], ir_q[7:4]);
  assign req_done = mem_req_q && mem_ready;
  // A store retires in the very cycle its write is accepted, so that pc_en follows mem_ready.
  assign st_done  = (state_q == S_ST) && req_done;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    addr_sel_d = 1'b0;
    ir_en_d    = 1'b0;
    pc_en_d    = 1'b0;
    pc_sel_d   = 2'd0;
    reg_we_d   = 1'b0;
    onehot_d   = '0;
    imm_mux_d  = 1'b0;
    wb_sel_d   = 1'b0;
    flag_en_d  = 1'b0;
    illegal_d  = 1'b0;
    retired_d  = retired_q + CNT_W'(pc_en);

    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (req_done) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (kind)
          K_LD:       state_d = S_LD;
          K_ST:       state_d = S_ST;
          K_JC, K_BC: state_d = S_BR;
          default:    state_d = S_ALU;
        endcase
      end
      S_LD:     if (req_done) state_d = S_LDWB;
      S_ST:     if (req_done) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    // Outputs are registered against the state being entered.
    case (state_d)
      S_FETCH:  mem_req_d = (state_q == S_FETCH && mem_req_q) || !halt;
      S_DECODE: ir_en_d = 1'b1;
      S_ALU: begin
        reg_we_d  = (kind != K_ILL);
        flag_en_d = (kind != K_ILL);
        imm_mux_d = (kind == K_IMM);
        illegal_d = (kind == K_ILL);
        pc_en_d   = 1'b1;
      end
      S_LD: begin
        mem_req_d  = 1'b1;
        addr_sel_d = 1'b1;
      end
      S_LDWB: begin
        reg_we_d = 1'b1;
        wb_sel_d = 1'b1;
        pc_en_d  = 1'b1;
      end
      S_ST: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        addr_sel_d = 1'b1;
      end
      S_BR: begin
        pc_en_d = 1'b1;
        if (cond_met(ir_q[11:8], flags)) pc_sel_d = (kind == K_BC) ? 2'd1 : 2'd2;
      end
      default: ;
    endcase

    if (reg_we_d) onehot_d = NUM_REGS'(1) << ir_q[8 +: REG_AW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      ir_en_q    <= 1'b0;
      pc_en_q    <= 1'b0;
      pc_sel_q   <= 2'd0;
      reg_we_q   <= 1'b0;
      onehot_q   <= '0;
      imm_mux_q  <= 1'b0;
      wb_sel_q   <= 1'b0;
      flag_en_q  <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      addr_sel_q <= addr_sel_d;
      ir_en_q    <= ir_en_d;
      pc_en_q    <= pc_en_d;
      pc_sel_q   <= pc_sel_d;
      reg_we_q   <= reg_we_d;
      onehot_q   <= onehot_d;
      imm_mux_q  <= imm_mux_d;
      wb_sel_q   <= wb_sel_d;
      flag_en_q  <= flag_en_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign addr_sel    = addr_sel_q;
  assign ir_en       = ir_en_q;
  assign pc_en       = pc_en_q | st_done;
  assign pc_sel      = pc_sel_q;
  assign reg_we      = reg_we_q;
  assign rdst_onehot = onehot_q;
  assign rdst_addr   = ir_q[8 +: REG_AW];
  assign rsrc_addr   = ir_q[0 +: REG_AW];
  assign alu_op      = {ir_q[15:12], ir_q[7:4]};
  assign imm_mux     = imm_mux_q;
  assign imm_out     = ir_q[IMM_W-1:0];
  assign wb_sel      = wb_sel_q;
  assign flag_en     = flag_en_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed cases then random instructions, each instruction
// checked against a per-instruction reference model of the expected control activity.
module tb_cpu_control_fsm;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic [15:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic [4:0]  flags = '0;
  logic        mem_req, mem_we, addr_sel, ir_en, pc_en, reg_we;
  logic [1:0]  pc_sel;
  logic [15:0] rdst_onehot;
  logic [3:0]  rdst_addr, rsrc_addr;
  logic [7:0]  alu_op;
  logic        imm_mux, wb_sel, flag_en, illegal;
  logic [7:0]  imm_out;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;
  int unsigned model_retired = 0;

  localparam int KR = 0, KIMM = 1, KLD = 2, KST = 3, KJ = 4, KB = 5, KILL = 6;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .halt(halt), .instr_in(instr_in), .mem_ready(mem_ready),
    .flags(flags), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
    .pc_en(pc_en), .pc_sel(pc_sel), .reg_we(reg_we), .rdst_onehot(rdst_onehot),
    .rdst_addr(rdst_addr), .rsrc_addr(rsrc_addr), .alu_op(alu_op), .imm_mux(imm_mux),
    .imm_out(imm_out), .wb_sel(wb_sel), .flag_en(flag_en), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_kind(input logic [15:0] i);
    int op, ext;
    op = int'(i[15:12]);
    ext = int'(i[7:4]);
    if (op == 0) return KR;
    if (op inside {1, 2, 3, 5, 8, 9, 11, 13}) return KIMM;
    if (op == 4) return (ext == 0) ? KLD : (ext == 4) ? KST : (ext == 12) ? KJ : KILL;
    if (op == 12) return KB;
    return KILL;
  endfunction

  function automatic bit model_taken(input logic [3:0] c, input logic [4:0] f);
    bit n, z, fl, l, cy;
    n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
    case (c)
      4'h0: return z;        4'h1: return !z;
      4'h2: return cy;       4'h3: return !cy;
      4'h4: return l;        4'h5: return !l;
      4'h6: return n;        4'h7: return !n;
      4'h8: return fl;       4'h9: return !fl;
      4'hA: return !l && !z; 4'hB: return l || z;
      4'hC: return !n && !z; 4'hD: return n || z;
      4'hE: return 1'b1;     default: return 1'b0;
    endcase
  endfunction

  // Plays memory for one instruction and tallies what the controller did over its lifetime.
  task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input int fdly,
                           input int ddly, input bit hmid, output int idle);
    int kind, exp_lat, cyc, fcnt, dcnt, we_n, fe_n, ill_n, ire_n, mwe_n, oh_bad;
    bit started, done;
    logic [1:0] exp_sel;
    kind = model_kind(ins);
    cyc = 0; fcnt = 0; dcnt = 0; we_n = 0; fe_n = 0; ill_n = 0; ire_n = 0; mwe_n = 0; oh_bad = 0;
    started = 0; done = 0; idle = 0;
    flags = fl;
    exp_sel = 2'd0;
    if ((kind == KB || kind == KJ) && model_taken(ins[11:8], fl)) exp_sel = (kind == KB) ? 2'd1 : 2'd2;
    exp_lat = 3 + fdly + ((kind == KLD) ? ddly + 1 : (kind == KST) ? ddly : 0);
    for (int k = 0; k < 64 && !done; k++) begin
      @(posedge clk); #1;
      if (!started && mem_req) begin
        started = 1;
        chk("retired_at_fetch", retired, model_retired);
      end
      if (!started) idle++;
      mem_ready = 1'b0;
      if (mem_req && !addr_sel) begin
        instr_in = ins;
        mem_ready = (fcnt == fdly);
        fcnt++;
        if (hmid && fcnt == 1) halt = 1'b1;
      end else if (mem_req) begin
        mem_ready = (dcnt == ddly);
        dcnt++;
      end
      #1;
      if (started) begin
        cyc++;
        if (ir_en) begin
          ire_n++;
          chk("alu_op", alu_op, {ins[15:12], ins[7:4]});
          chk("rdst_addr", rdst_addr, ins[11:8]);
          chk("rsrc_addr", rsrc_addr, ins[3:0]);
          chk("imm_out", imm_out, ins[7:0]);
        end
        if (reg_we) begin
          we_n++;
          chk("rdst_onehot", rdst_onehot, 16'(1) << ins[11:8]);
          chk("wb_sel", wb_sel, kind == KLD);
          chk("imm_mux", imm_mux, kind == KIMM);
        end else if (rdst_onehot != 16'h0) oh_bad++;
        fe_n += int'(flag_en);
        ill_n += int'(illegal);
        mwe_n += int'(mem_we);
        if (pc_en) begin
          done = 1;
          chk("pc_sel", pc_sel, exp_sel);
          chk("retired_at_pc_en", retired, model_retired);
        end
      end
    end
    chk("instr_completed", done, 1);
    chk("latency", cyc, exp_lat);
    chk("fetch_req_cycles", fcnt, fdly + 1);
    chk("data_req_cycles", dcnt, (kind == KLD || kind == KST) ? ddly + 1 : 0);
    chk("reg_we_cycles", we_n, (kind == KR || kind == KIMM || kind == KLD) ? 1 : 0);
    chk("flag_en_cycles", fe_n, (kind == KR || kind == KIMM) ? 1 : 0);
    chk("illegal_pulses", ill_n, (kind == KILL) ? 1 : 0);
    chk("ir_en_pulses", ire_n, 1);
    chk("mem_we_cycles", mwe_n, (kind == KST) ? ddly + 1 : 0);
    chk("onehot_without_we", oh_bad, 0);
    model_retired++;
  endtask

  initial begin
    int idle;
    logic [15:0] ins;
    #2 reset = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_retired", retired, 0);
    chk("rst_alu_op", alu_op, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("release_mem_req_low", mem_req, 0);

    run_instr(16'h0152, 5'b00000, 0, 0, 0, idle);
    chk("first_fetch_idle", idle, 0);
    run_instr(16'h4304, 5'b00000, 0, 3, 0, idle);
    run_instr(16'hC005, 5'b01000, 0, 0, 0, idle);
    run_instr(16'hC005, 5'b00000, 1, 0, 0, idle);
    run_instr(16'h4EC3, 5'b00000, 0, 0, 0, idle);
    run_instr(16'h4742, 5'b00000, 0, 2, 0, idle);
    run_instr(16'h6123, 5'b11111, 0, 0, 0, idle);
    run_instr(16'h51FF, 5'b00000, 2, 0, 0, idle);
    run_instr(16'hCA12, 5'b00010, 0, 0, 0, idle);

    for (int i = 0; i < 150; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ins[15:12] = 4'h4;
        case ($urandom_range(0, 3))
          0: ins[7:4] = 4'h0;
          1: ins[7:4] = 4'h4;
          2: ins[7:4] = 4'hC;
          default: ;
        endcase
      end
      run_instr(ins, 5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, idle);
    end

    // Halt raised while a fetch is outstanding: that fetch must finish, the next must not start.
    run_instr(16'h0321, 5'b00000, 2, 0, 1, idle);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("halt_no_req", mem_req, 0);
      chk("halt_no_pc_en", pc_en, 0);
    end
    halt = 1'b0;
    @(posedge clk); #1;
    chk("halt_release_req", mem_req, 1);
    chk("halted_retired", retired, model_retired);

    // Reset while the fetch request is outstanding drops it without waiting for a clock.
    reset = 1'b0;
    #1;
    chk("reset_drops_req", mem_req, 0);
    chk("reset_clears_retired", retired, 0);
    model_retired = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_instr(16'h1A7F, 5'b00000, 1, 0, 0, idle);
    chk("post_reset_idle", idle, 0);
    run_instr(16'h4000, 5'b00000, 0, 0, 0, idle);

    @(posedge clk); #1;
    chk("final_retired", retired, model_retired);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
